// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker; on a tie the port other than last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) gnt_idx = ~last;
    else if (req[1])  gnt_idx = 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (port 0) and load/store (port 1): ack 2 cycles after request, one access per 3 cycles.
// Requesters hold req until ack; optional MEM_ARB_ALIGN_CHECK_EN suppresses misaligned writes and flags err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);
  state_t                state_q, state_d;
  logic                  last_q, sel_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  logic                  gnt_idx, gnt_valid;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_misaligned;

  rr_arb2 u_rr (
    .req       ({m1_req, m0_req}),
    .last      (last_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (gnt_idx == REQ_LS) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;

  assign win_misaligned = (win_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == IDLE && gnt_valid) err_q <= win_misaligned;
  end

  assign err = (state_q == ACK) && err_q;
`else
  assign win_misaligned = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = BUSY;
      BUSY:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured on writes too, so rdata_q always reflects the last access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_valid) begin
        sel_q   <= gnt_idx;
        last_q  <= gnt_idx;
        we_q    <= win_we && !win_misaligned;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      if (state_q == BUSY) rdata_q <= mem_dataout;
    end
  end

  // Decoded from registered state so a reset asserted during BUSY cannot cancel that cycle's write.
  always_comb begin
    mem_addr = addr_q;
    mem_data = wdata_q;
    mem_we   = (state_q == BUSY) && we_q;
    m0_ack   = (state_q == ACK) && (sel_q == REQ_IF);
    m1_ack   = (state_q == ACK) && (sel_q == REQ_LS);
    m0_rdata = rdata_q;
    m1_rdata = rdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural MEM and an ack scoreboard.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, err, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_data, mem_dataout;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    bit          port;
    bit          chk_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign mem_dataout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_data;

  mem_arbiter dut (
    .clk (clk), .rst (rst),
    .m0_req (m0_req), .m0_we (m0_we), .m0_addr (m0_addr), .m0_wdata (m0_wdata),
    .m0_ack (m0_ack), .m0_rdata (m0_rdata),
    .m1_req (m1_req), .m1_we (m1_we), .m1_addr (m1_addr), .m1_wdata (m1_wdata),
    .m1_ack (m1_ack), .m1_rdata (m1_rdata),
    .err (err), .mem_addr (mem_addr), .mem_data (mem_data), .mem_we (mem_we),
    .mem_dataout (mem_dataout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest pending expectation.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      chk("ack_exclusive", {31'd0, m0_ack && m1_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", {31'd0, m1_ack}, {31'd0, e.port});
        chk("ack_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_data) chk("ack_rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
      end
    end else if (err) begin
      chk("err_without_ack", 32'd1, 32'd0);
    end
  end

  task automatic set_req(input bit p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p) begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic push_exp(input bit p, input logic [31:0] a);
    exp_t e;
    bit   mis;
    mis        = ALIGN && (a[1:0] != 2'b00);
    e.port     = p;
    e.chk_data = !mis;
    e.rdata    = ref_mem[a[7:2]];
    e.err      = mis;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single access from IDLE; leaves the bench in the following IDLE cycle.
  task automatic access(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit mis;
    int lat, wc;
    mis = ALIGN && (a[1:0] != 2'b00);
    lat = 0;
    wc  = 0;
    push_exp(p, a);
    set_req(p, 1, we, a, d);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (mem_we) wc++;
      if (p ? m1_ack : m0_ack) lat = i;
    end
    chk("ack_latency", lat, 2);
    chk("mem_we_cycles", wc, (we && !mis) ? 1 : 0);
    if (we && !mis) ref_mem[a[7:2]] = d;
    set_req(p, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    int t0, t1, n;
    int ack_cyc[$];
    bit ack_port[$];
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    do_reset();
    chk("rst_m0_ack", {31'd0, m0_ack}, 0);
    chk("rst_m1_ack", {31'd0, m1_ack}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_rdata", m0_rdata, 0);

    // Single write then read-back from port 0.
    access(0, 1, 32'h8, 32'hDEADBEEF);
    access(0, 0, 32'h8, 32'h0);

    // First tie after reset goes to port 0.
    do_reset();
    push_exp(0, 32'h8);
    push_exp(1, 32'h4);
    set_req(0, 1, 0, 32'h8, 0);
    set_req(1, 1, 1, 32'h4, 32'h11);
    t0 = 0;
    t1 = 0;
    for (int i = 1; i <= 12 && t1 == 0; i++) begin
      tick();
      if (m0_ack) begin t0 = i; set_req(0, 0, 0, 0, 0); end
      if (m1_ack) begin t1 = i; set_req(1, 0, 0, 0, 0); end
    end
    chk("tie_m0_cycle", t0, 2);
    chk("tie_m1_cycle", t1, 5);
    ref_mem[1] = 32'h11;
    tick();
    access(1, 0, 32'h4, 0);

    // Continuous contention for 12 cycles; last grant was port 1.
    push_exp(0, 32'h8);
    push_exp(1, 32'h4);
    push_exp(0, 32'h8);
    push_exp(1, 32'h4);
    set_req(0, 1, 0, 32'h8, 0);
    set_req(1, 1, 0, 32'h4, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (m0_ack) begin ack_cyc.push_back(k); ack_port.push_back(1'b0); end
      if (m1_ack) begin ack_cyc.push_back(k); ack_port.push_back(1'b1); end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    n = ack_cyc.size();
    chk("cont_ack_count", n, 4);
    for (int j = 0; j < n && j < 4; j++) begin
      chk("cont_ack_cycle", ack_cyc[j], 2 + 3 * j);
      chk("cont_ack_port", {31'd0, ack_port[j]}, j % 2);
    end
    tick();

    // Reset asserted during BUSY: write lands, no ack.
    set_req(1, 1, 1, 32'hC, 32'h55);
    tick();
    chk("rstbusy_mem_we", {31'd0, mem_we}, 1);
    rst = 1'b1;
    set_req(1, 0, 0, 0, 0);
    tick();
    chk("rstbusy_no_ack", {31'd0, m1_ack}, 0);
    rst = 1'b0;
    ref_mem[3] = 32'h55;
    tick();
    tick();
    access(0, 0, 32'hC, 0);

    // Back-to-back from port 1 with new fields presented at ack.
    push_exp(1, 32'h14);
    set_req(1, 1, 1, 32'h14, 32'h33);
    t0 = 0;
    t1 = 0;
    for (int i = 1; i <= 12 && t1 == 0; i++) begin
      tick();
      if (m1_ack && t0 == 0) begin
        t0 = i;
        ref_mem[5] = 32'h33;
        push_exp(1, 32'h10);
        set_req(1, 1, 1, 32'h10, 32'h44);
      end else if (m1_ack) begin
        t1 = i;
        set_req(1, 0, 0, 0, 0);
      end
    end
    chk("b2b_first_ack", t0, 2);
    chk("b2b_spacing", t1 - t0, 3);
    ref_mem[4] = 32'h44;
    tick();
    access(0, 0, 32'h10, 0);
    access(1, 0, 32'h14, 0);

    // Misaligned write: suppressed with err when alignment checking is built in.
    access(0, 1, 32'h6, 32'h77);
    access(0, 0, 32'h4, 0);

    tick();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
